int_ram: RTL and testbench

Two-bank, single-port, synchronous-read internal RAM for the LDPC decoder datapath. It holds quantized message values (default 5-bit), for example the current and next iteration of variable/check messages. A register-select input picks one of two independent banks that share the same address space. One port serves either a write or a registered read each clock.

---
 rtl/int_ram_pkg.sv | 12 +
 rtl/int_ram_bank.sv | 25 ++
 rtl/int_ram.sv | 67 ++++++
 tb/tb_int_ram.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/int_ram_pkg.sv
// Shared constants for the two-bank LDPC message RAM.
// Default geometry and the bank-select encoding.
package int_ram_pkg;

   localparam int DATA_WIDTH    = 5;
   localparam int ADDRESS_WIDTH = 8;
   localparam int RAM_DEPTH     = 256;

   localparam logic BANK0 = 1'b0;
   localparam logic BANK1 = 1'b1;

endpackage

// File: rtl/int_ram_bank.sv
// One bank of message storage: synchronous write, combinational read word.
// The owner registers the read word, keeping the array free of reset.
module int_ram_bank #(
   parameter int DATA_WIDTH    = int_ram_pkg::DATA_WIDTH,
   parameter int ADDRESS_WIDTH = int_ram_pkg::ADDRESS_WIDTH,
   parameter int RAM_DEPTH     = int_ram_pkg::RAM_DEPTH
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [ADDRESS_WIDTH-1:0] address,
   input  logic [DATA_WIDTH-1:0]    data_in,
   output logic [DATA_WIDTH-1:0]    q
);

   logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[address] <= data_in;
      end
   end

   assign q = mem[address];

endmodule

// File: rtl/int_ram.sv
// Two-bank single-port RAM with a registered read port.
// rs steers the write enable and the read mux; banks share addressing.
module int_ram #(
   parameter int DATA_WIDTH    = int_ram_pkg::DATA_WIDTH,
   parameter int ADDRESS_WIDTH = int_ram_pkg::ADDRESS_WIDTH,
   parameter int RAM_DEPTH     = int_ram_pkg::RAM_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cs,
   input  logic                     rs,
   input  logic                     we,
   input  logic [ADDRESS_WIDTH-1:0] address,
   input  logic [DATA_WIDTH-1:0]    data_in,
   output logic [DATA_WIDTH-1:0]    data_out
);

   import int_ram_pkg::*;

   if (RAM_DEPTH != 2**ADDRESS_WIDTH) begin : g_depth_check
      $error("int_ram: RAM_DEPTH must equal 2**ADDRESS_WIDTH");
   end

   logic                  wr;
   logic                  we0;
   logic                  we1;
   logic [DATA_WIDTH-1:0] q0;
   logic [DATA_WIDTH-1:0] q1;

   // Reset takes priority over any access, including writes.
   assign wr  = cs & we & ~rst;
   assign we0 = wr & (rs == BANK0);
   assign we1 = wr & (rs == BANK1);

   int_ram_bank #(
      .DATA_WIDTH    (DATA_WIDTH),
      .ADDRESS_WIDTH (ADDRESS_WIDTH),
      .RAM_DEPTH     (RAM_DEPTH)
   ) u_bank0 (
      .clk     (clk),
      .we      (we0),
      .address (address),
      .data_in (data_in),
      .q       (q0)
   );

   int_ram_bank #(
      .DATA_WIDTH    (DATA_WIDTH),
      .ADDRESS_WIDTH (ADDRESS_WIDTH),
      .RAM_DEPTH     (RAM_DEPTH)
   ) u_bank1 (
      .clk     (clk),
      .we      (we1),
      .address (address),
      .data_in (data_in),
      .q       (q1)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         data_out <= '0;
      end else if (cs && !we) begin
         data_out <= (rs == BANK1) ? q1 : q0;
      end
   end

endmodule

// File: tb/tb_int_ram.sv
// Directed bench for int_ram: bank fills, readback, and a vector table
// covering latency, hold, reset, chip-select gating and bank isolation.
module tb_int_ram;

   localparam int DW = 5;
   localparam int AW = 8;
   localparam int DEPTH = 256;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          cs = 1'b0;
   logic          rs = 1'b0;
   logic          we = 1'b0;
   logic [AW-1:0] address = '0;
   logic [DW-1:0] data_in = '0;
   logic [DW-1:0] data_out;

   int checks = 0;
   int fails = 0;

   always #5 clk = ~clk;

   int_ram #(
      .DATA_WIDTH    (DW),
      .ADDRESS_WIDTH (AW),
      .RAM_DEPTH     (DEPTH)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .cs       (cs),
      .rs       (rs),
      .we       (we),
      .address  (address),
      .data_in  (data_in),
      .data_out (data_out)
   );

   typedef struct {
      logic          rst;
      logic          cs;
      logic          rs;
      logic          we;
      logic [AW-1:0] address;
      logic [DW-1:0] data_in;
      logic [DW-1:0] exp_q;
      string         name;
   } vec_t;

   localparam int NV = 21;
   vec_t vecs [NV];

   task automatic drive(input logic r, input logic c, input logic b,
                        input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
      rst = r;
      cs = c;
      rs = b;
      we = w;
      address = a;
      data_in = d;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [DW-1:0] exp_q);
      checks++;
      if (data_out !== exp_q) begin
         fails++;
         $display("FAIL %s: data_out=%h expected=%h at %0t",
                  name, data_out, exp_q, $time);
      end
   endtask

   function automatic vec_t mk(input logic r, input logic c,
                               input logic b, input logic w,
                               input int a, input int d,
                               input int e, input string n);
      vec_t v;
      v.rst = r;
      v.cs = c;
      v.rs = b;
      v.we = w;
      v.address = AW'(a);
      v.data_in = DW'(d);
      v.exp_q = DW'(e);
      v.name = n;
      return v;
   endfunction

   initial begin
      // data_out before this table is the bank1 read of address 0: 3
      vecs[0]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 'h2A, 'h15, 3, "lat_wr_hold");
      vecs[1]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 'h2A, 0, 'h15, "lat_rd");
      vecs[2]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 'h15, "cs0_hold_a");
      vecs[3]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 1, 7, 'h15, "cs0_hold_b");
      vecs[4]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 'h2A, 0, 'h15, "cs0_hold_c");
      vecs[5]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 5, 0, 5, "rd_a5");
      vecs[6]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 6, 'h1F, 5, "wr_no_disturb");
      vecs[7]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 6, 0, 'h1F, "rd_a6");
      vecs[8]  = mk(1'b1, 1'b1, 1'b0, 1'b1, 6, 0, 0, "rst_clears_q");
      vecs[9]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 6, 0, 'h1F, "rst_keeps_mem");
      vecs[10] = mk(1'b0, 1'b0, 1'b0, 1'b1, 9, 'h0A, 'h1F, "cs0_wr_hold");
      vecs[11] = mk(1'b0, 1'b1, 1'b0, 1'b0, 9, 0, 3, "cs0_no_write");
      vecs[12] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1, 0, 1, "cs0_no_write_b");
      vecs[13] = mk(1'b0, 1'b1, 1'b1, 1'b0, 6, 0, 3, "iso_b1_a6");
      vecs[14] = mk(1'b0, 1'b1, 1'b1, 1'b1, 'h2A, 'h0B, 3, "b1_wr_hold");
      vecs[15] = mk(1'b0, 1'b1, 1'b0, 1'b0, 'h2A, 0, 'h15, "iso_b0_2a");
      vecs[16] = mk(1'b0, 1'b1, 1'b1, 1'b0, 'h2A, 0, 'h0B, "b1_rd_2a");
      vecs[17] = mk(1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 3, "b1_rd_a0");
      vecs[18] = mk(1'b0, 1'b1, 1'b0, 1'b1, 255, 'h1E, 3, "b2b_wr");
      vecs[19] = mk(1'b0, 1'b1, 1'b0, 1'b0, 255, 0, 'h1E, "b2b_rd");
      vecs[20] = mk(1'b0, 1'b1, 1'b1, 1'b0, 255, 0, 0, "iso_b1_ff");

      // reset with a write request pending
      drive(1'b1, 1'b1, 1'b0, 1'b1, 0, 5'h1F);
      check("reset_q", 5'h00);

      for (int a = 0; a < DEPTH; a++) begin
         drive(1'b0, 1'b1, 1'b0, 1'b1, AW'(a), DW'(a % 6));
      end
      check("fill_b0_hold", 5'h00);

      for (int a = 0; a < DEPTH; a++) begin
         drive(1'b0, 1'b1, 1'b0, 1'b0, AW'(a), '0);
         check("rd_b0", DW'(a % 6));
      end

      for (int a = 0; a < DEPTH; a++) begin
         drive(1'b0, 1'b1, 1'b1, 1'b1, AW'(a), DW'((a + 3) % 6));
      end

      for (int a = 0; a < DEPTH; a++) begin
         drive(1'b0, 1'b1, 1'b0, 1'b0, AW'(a), '0);
         check("reread_b0", DW'(a % 6));
      end

      for (int a = DEPTH - 1; a >= 0; a--) begin
         drive(1'b0, 1'b1, 1'b1, 1'b0, AW'(a), '0);
         check("rd_b1", DW'((a + 3) % 6));
      end

      for (int i = 0; i < NV; i++) begin
         drive(vecs[i].rst, vecs[i].cs, vecs[i].rs, vecs[i].we,
               vecs[i].address, vecs[i].data_in);
         check(vecs[i].name, vecs[i].exp_q);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               checks, fails);
      $finish;
   end

endmodule
